// File: rtl/mem_copy_seq.sv
// Multi-word memory-copy sequencer: on the copy opcode it stalls the core,
// moves a block of words with alternating load/store transactions on the
// data-memory port and then releases the core with a one-cycle done pulse.
module mem_copy_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 8,
  parameter logic [6:0]  COPY_OP = 7'b1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned OP_W   = 7;
  localparam int unsigned LEN_LO = 7;
  localparam int unsigned STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] data_buf;
  logic [LEN_W-1:0]  count;
  logic              start;
  logic              unused_instr;

  assign count        = instr[LEN_LO +: LEN_W];
  assign unused_instr = ^instr[31:LEN_LO+LEN_W];
  assign mem_wdata    = data_buf;

  // Start detect and PC stall; stall must cover the detect cycle itself and
  // is forced low while reset is asserted.
  always_comb begin
    start = 1'b0;
    stall = 1'b0;
    start = (state == IDLE) && (instr[OP_W-1:0] == COPY_OP);
    stall = rst_n && (start || (state == LOAD) || (state == STORE));
  end

  // Sequencer state, pointers and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_buf  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_base;
            dst_ptr   <= dst_base;
            remaining <= count;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= src_base;
            end
          end
        end
        LOAD: begin
          if (mem_ready) begin
            data_buf <= mem_rdata;
            state    <= STORE;
            mem_we   <= 1'b1;
            mem_addr <= dst_ptr;
          end
        end
        STORE: begin
          if (mem_ready) begin
            src_ptr   <= src_ptr + ADDR_W'(STRIDE);
            dst_ptr   <= dst_ptr + ADDR_W'(STRIDE);
            remaining <= remaining - LEN_W'(1);
            mem_we    <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              state   <= DONE;
              busy    <= 1'b0;
              mem_req <= 1'b0;
              done    <= 1'b1;
            end else begin
              state    <= LOAD;
              mem_addr <= src_ptr + ADDR_W'(STRIDE);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_seq.sv
// Bench for mem_copy_seq: memory model, transaction scoreboard and copy scenarios.
module tb_mem_copy_seq;

  localparam logic [6:0] COPY = 7'b1000000;
  localparam logic [6:0] LDOP = 7'b0000011;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] src_base, dst_base;
  logic        stall, busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  logic [31:0] mem [logic [31:0]];
  txn_t        exp_q [$];
  logic [31:0] src_words [0:15];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_txn = 0;
  int          done_total = 0;
  logic [31:0] hold_addr;
  logic        hold_we;

  mem_copy_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .src_base (src_base),
    .dst_base (dst_base),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [7:0] n);
    return {17'b0, n, op};
  endfunction

  // Memory model: stretches mem_ready by wait_n cycles, scores each handshake.
  always @(negedge clk) begin
    if (done) done_total++;
    mem_rdata = 32'hBAD0_BAD0;
    if (mem_req) begin
      if (wcnt < wait_n) begin
        mem_ready = 1'b0;
        wcnt++;
        if (wcnt == 1) begin
          hold_addr = mem_addr;
          hold_we   = mem_we;
        end else begin
          check("wait_stable", {31'b0, mem_we, mem_addr}, {31'b0, hold_we, hold_addr});
        end
      end else begin
        mem_ready = 1'b1;
        wcnt = 0;
        n_txn++;
        if (exp_q.size() == 0) begin
          check("unexpected_txn", {31'b0, mem_we, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          check("txn_kind_addr", {31'b0, mem_we, mem_addr}, {31'b0, e.we, e.addr});
          if (e.we) check("txn_wdata", {32'b0, mem_wdata}, {32'b0, e.data});
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = rd(mem_addr);
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Drive a copy instruction and push its expected transaction sequence.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      logic [31:0] sa;
      w  = $urandom;
      sa = src + 32'(4 * i);
      mem[sa] = w;
      src_words[i] = w;
      exp_q.push_back('{1'b0, sa, 32'h0});
      exp_q.push_back('{1'b1, dst + 32'(4 * i), w});
    end
    src_base = src;
    dst_base = dst;
    instr    = mk(COPY, 8'(n));
  endtask

  // Count stalled cycles up to the done pulse; instr stays on the copy op through DONE.
  task automatic wait_done(input string tag, input int exp_stall);
    int stalls = 0;
    int cyc = 0;
    int done_cyc = 0;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) stalls++;
      if (done) begin
        done_cyc = cyc;
        check({tag, "_stall_in_done"}, {63'b0, stall}, 64'd0);
      end
    end
    check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_stall + 1));
    @(posedge clk); #1;
    instr = mk(LDOP, 8'd0);
    @(negedge clk);
    check({tag, "_no_restart"}, {60'b0, busy, stall, mem_req, done}, 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++)
      check(tag, {32'b0, rd(dst + 32'(4 * i))}, {32'b0, src_words[i]});
  endtask

  initial begin
    int t0;
    rst_n     = 1'b0;
    instr     = mk(LDOP, 8'd0);
    src_base  = '0;
    dst_base  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {59'b0, stall, busy, done, mem_req, mem_we}, 64'd0);
    check("rst_addr", {32'b0, mem_addr}, 64'd0);
    check("rst_wdata", {32'b0, mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // Three words, always ready.
    start_copy(32'h100, 32'h200, 3);
    wait_done("c3", 7);
    check_mem("c3_data", 32'h200, 3);

    // Zero-length copy: one stalled cycle, no transactions.
    t0 = n_txn;
    start_copy(32'h400, 32'h500, 0);
    wait_done("c0", 1);
    check("c0_no_txn", 64'(n_txn - t0), 64'd0);

    // Two words with two wait cycles before every grant.
    wait_n = 2;
    start_copy(32'h600, 32'h700, 2);
    wait_done("c2w", 13);
    check_mem("c2w_data", 32'h700, 2);
    wait_n = 0;

    // Source pointer wraps from the top of the address space to zero.
    start_copy(32'hFFFF_FFFC, 32'h300, 2);
    wait_done("wrap", 5);
    check_mem("wrap_data", 32'h300, 2);

    // Non-copy opcode never stalls or touches memory.
    @(posedge clk); #1;
    instr = mk(LDOP, 8'd3);
    repeat (3) begin
      @(negedge clk);
      check("ld_idle", {62'b0, stall, mem_req}, 64'd0);
    end

    // Reset during the second store of a four-word copy.
    t0 = done_total;
    start_copy(32'h800, 32'h900, 4);
    repeat (5) @(negedge clk);
    check("mid_in_store", {62'b0, busy, mem_we}, 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {59'b0, stall, busy, done, mem_req, mem_we}, 64'd0);
    check("mid_rst_addr", {mem_addr, mem_wdata}, 64'd0);
    exp_q.delete();
    instr = mk(LDOP, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_no_done", 64'(done_total - t0), 64'd0);
    check("mid_partial", {32'b0, rd(32'h900)}, {32'b0, src_words[0]});

    // Fresh copy after the aborted one.
    start_copy(32'hA00, 32'hB00, 2);
    wait_done("post", 5);
    check_mem("post_data", 32'hB00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_copy_seq.md
Name: mem_copy_seq

Overview:
- Multi-word memory-copy sequencer for the single-cycle core.
- Detects the custom copy opcode (7'b1000000) at the fetch/decode boundary and stalls the PC.
- Moves a block of words by issuing alternating load/store transactions on the data-memory port, then releases the core.
- Sits beside decode and arbitrates the data-memory port: the core owns the port while idle, this block owns it while busy.

Parameters:
- ADDR_W, 32, address width; byte addressing, word stride 4.
- DATA_W, 32, data word width.
- LEN_W, 8, width of the word-count field.
- COPY_OP, 7'b1000000, opcode value that triggers a copy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  current instruction; [6:0] opcode, [14:7] word count.
- src_base  in  ADDR_W  rs1 value, source start address.
- dst_base  in  ADDR_W  rs2 value, destination start address.
- stall  out  1  hold PC and suppress core writeback.
- busy  out  1  high in LOAD or STORE.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  data-memory request, owned by this block when high.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid when mem_ready is high.
- mem_ready  in  1  transfer completes on a cycle where mem_req and mem_ready are both high.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; src_ptr, dst_ptr, remaining and data_buf all 0. This gives stall=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- start = (state==IDLE) && (instr[6:0]==COPY_OP). start is ignored in every other state.
- States: IDLE, LOAD, STORE, DONE.
- IDLE:
  - on start, latch src_ptr<=src_base, dst_ptr<=dst_base, remaining<=instr[14:7];
  - if instr[14:7]==0, go to DONE, otherwise go to LOAD.
- LOAD:
  - mem_req=1, mem_we=0, mem_addr=src_ptr;
  - on mem_ready: data_buf<=mem_rdata, go to STORE; otherwise hold, outputs stable.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=dst_ptr, mem_wdata=data_buf;
  - on mem_ready: src_ptr+=4, dst_ptr+=4 (modulo 2^ADDR_W, wraps silently), remaining-=1;
  - then go to DONE if remaining==1, otherwise go to LOAD.
- DONE: done=1, stall=0, mem_req=0; next state IDLE unconditionally. The copy instruction is still on instr in this cycle and must not restart.
- stall = (state==IDLE && start) || state==LOAD || state==STORE. stall is combinational so the PC holds in the detect cycle.
- busy = state==LOAD || state==STORE. done is decoded from state.
- Latency with mem_ready tied high: N words take 2N+1 stalled cycles, then one DONE cycle. N=0 takes 1 stalled cycle, then DONE.
- Outside LOAD/STORE: mem_req=0; mem_addr and mem_wdata hold their last values, don't-care to the core.
- Overlapping source and destination: no hazard handling; words are copied strictly in ascending order.
- Reset mid-copy: immediate return to IDLE with all outputs 0. Words already stored remain in memory; the partial copy is not reported as done.
- mem_rdata is sampled only in LOAD with mem_ready=1.

Test Plan:
- instr count=3, src=0x100, dst=0x200, mem_ready=1 -> stall high 7 cycles; transaction sequence L100, S200, L104, S204, L108, S208; done pulses once in cycle 8; memory at 0x200..0x208 equals memory at 0x100..0x108.
- count=0 -> stall high 1 cycle, no mem_req, done in cycle 2.
- count=2 with mem_ready low 2 cycles before each grant -> mem_addr and mem_we stable while waiting; stall high 13 cycles; data correct.
- src=0xFFFFFFFC, count=2 -> second load address is 0x00000000.
- Copy instruction held on instr during DONE and after done -> no second copy starts from DONE; opcode 7'b0000011 -> stall=0, mem_req=0.
- rst_n low during the second STORE of a count=4 copy -> all outputs 0 asynchronously; no done pulse; next start copies correctly.
